// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler: queues EX branch/JAL resolutions and drains them
// into the predictor write port, and sequences a full-table clear on interrupt flush.
module bp_update_sched #(
    parameter  int FIFO_DEPTH = 4,
    parameter  int ENTRIES    = 16,
    localparam int IDX_W      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_DONE,
    input  logic             MEM_DONE,
    input  logic             irq_flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_btype,
    input  logic             ex_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    output logic             wr_valid,
    output logic [1:0]       wr_btype,
    output logic             wr_taken,
    output logic [31:0]      wr_pc,
    output logic [31:0]      wr_target,
    output logic             clr_valid,
    output logic [IDX_W-1:0] clr_idx,
    output logic             pred_en,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: an EX resolution transfers on any cycle where ex_valid && ex_ready;
    // only JAL/B-type transfers are stored, other btypes are accepted and dropped.

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]  btype;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } upd_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    upd_t             fifo_mem [FIFO_DEPTH];

    logic is_run;
    logic not_empty;
    logic not_full;
    logic is_branch;
    logic push;
    logic pop;
    upd_t head;
    upd_t ex_entry;

    assign is_run    = (state == RUN);
    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(FIFO_DEPTH));
    assign is_branch = (ex_btype == 2'b01) || (ex_btype == 2'b10);

    // A flush request suppresses both sides of the FIFO in the cycle it is seen.
    assign wr_valid = is_run && not_empty && IF_DONE && MEM_DONE && !irq_flush;
    assign ex_ready = is_run && !irq_flush && (not_full || wr_valid);

    assign push = ex_valid && ex_ready && is_branch;
    assign pop  = wr_valid;

    assign ex_entry = '{btype: ex_btype, taken: ex_taken, pc: ex_pc, target: ex_target};

    always_comb begin
        head = '0;
        if (not_empty) begin
            head = fifo_mem[rd_ptr];
        end
    end

    assign wr_btype  = head.btype;
    assign wr_taken  = head.taken;
    assign wr_pc     = head.pc;
    assign wr_target = head.target;

    assign clr_valid = (state == FLUSH);
    assign pred_en   = is_run;
    assign busy      = (state == FLUSH) || not_empty;

    // Payload storage carries no reset; reads are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ex_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            clr_idx <= '0;
        end else if (irq_flush) begin
            state   <= FLUSH;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            clr_idx <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   count <= count + CNT_W'(1);
                        2'b01:   count <= count - CNT_W'(1);
                        default: count <= count;
                    endcase
                end
                FLUSH: begin
                    if (clr_idx == IDX_W'(ENTRIES - 1)) begin
                        state   <= RUN;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    clr_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: scenario tasks with inline checks plus a write-port
// scoreboard fed from accepted EX handshakes.
module tb_bp_update_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int ENTRIES    = 16;
    localparam int IDX_W      = 4;
    localparam int W          = 67;

    logic             clk;
    logic             rst;
    logic             IF_DONE;
    logic             MEM_DONE;
    logic             irq_flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [1:0]       ex_btype;
    logic             ex_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             wr_valid;
    logic [1:0]       wr_btype;
    logic             wr_taken;
    logic [31:0]      wr_pc;
    logic [31:0]      wr_target;
    logic             clr_valid;
    logic [IDX_W-1:0] clr_idx;
    logic             pred_en;
    logic             busy;

    logic [W-1:0] exp_q[$];
    int n_run;
    int n_fail;

    bp_update_sched #(.FIFO_DEPTH(FIFO_DEPTH), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .IF_DONE(IF_DONE), .MEM_DONE(MEM_DONE),
        .irq_flush(irq_flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_btype(ex_btype), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .wr_valid(wr_valid), .wr_btype(wr_btype), .wr_taken(wr_taken), .wr_pc(wr_pc),
        .wr_target(wr_target), .clr_valid(clr_valid), .clr_idx(clr_idx),
        .pred_en(pred_en), .busy(busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // scoreboard: pop on every write, push on every stored handshake
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            if (wr_valid) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got pc=%h tgt=%h, expected no write", wr_pc, wr_target);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_btype, wr_taken, wr_pc, wr_target} !== e) begin
                        n_fail++;
                        $display("FAIL write_fields: got bt=%0d tk=%0d pc=%h tgt=%h, expected bt=%0d tk=%0d pc=%h tgt=%h",
                                 wr_btype, wr_taken, wr_pc, wr_target, e[66:65], e[64], e[63:32], e[31:0]);
                    end
                end
            end
            if (irq_flush) begin
                exp_q.delete();
            end else if (ex_valid && ex_ready && (ex_btype == 2'b01 || ex_btype == 2'b10)) begin
                exp_q.push_back({ex_btype, ex_taken, ex_pc, ex_target});
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [1:0] bt, input logic tk,
                            input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid  = v;
        ex_btype  = bt;
        ex_taken  = tk;
        ex_pc     = pc;
        ex_target = tgt;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && (exp_q.size() != 0 || busy !== 1'b0); c++) begin
            next_cycle();
        end
        n_run++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending, busy=%0b, expected 0 pending, busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic walk_once(input int restart_at);
        for (int k = 0; k < ENTRIES; k++) begin
            logic [IDX_W-1:0] ki;
            ki = k[IDX_W-1:0];
            if (k == restart_at) irq_flush = 1'b1;
            @(negedge clk);
            n_run++;
            if ({clr_valid, clr_idx, pred_en, wr_valid, ex_ready, busy} !== {1'b1, ki, 4'b0001}) begin
                n_fail++;
                $display("FAIL walk_step%0d: got clr=%0b idx=%0d pred=%0b wr=%0b rdy=%0b busy=%0b, expected clr=1 idx=%0d pred=0 wr=0 rdy=0 busy=1",
                         k, clr_valid, clr_idx, pred_en, wr_valid, ex_ready, busy, k);
            end
            next_cycle();
            if (k == restart_at) begin
                irq_flush = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_run(input string name);
        @(negedge clk);
        n_run++;
        if ({clr_valid, clr_idx, pred_en, wr_valid, ex_ready, busy} !== {1'b0, 4'd0, 4'b1010}) begin
            n_fail++;
            $display("FAIL %s_run: got clr=%0b idx=%0d pred=%0b wr=%0b rdy=%0b busy=%0b, expected clr=0 idx=0 pred=1 wr=0 rdy=1 busy=0",
                     name, clr_valid, clr_idx, pred_en, wr_valid, ex_ready, busy);
        end
        next_cycle();
    endtask

    // scenarios
    task automatic test_reset();
        #2;
        n_run++;
        if ({wr_valid, clr_valid, wr_btype, wr_taken, wr_pc, wr_target, clr_idx, pred_en, ex_ready, busy}
            !== {73'd0, 4'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL reset_values: got wr=%0b clr=%0b pc=%h idx=%0d pred=%0b rdy=%0b busy=%0b, expected 0 0 0 0 1 1 0",
                     wr_valid, clr_valid, wr_pc, clr_idx, pred_en, ex_ready, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_order();
        drive_ex(1'b1, 2'b10, 1'b1, 32'h100, 32'h80);
        @(negedge clk);
        n_run++;
        if ({ex_ready, wr_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL order_c1: got rdy=%0b wr=%0b, expected rdy=1 wr=0", ex_ready, wr_valid);
        end
        next_cycle();
        drive_ex(1'b1, 2'b01, 1'b1, 32'h104, 32'h200);
        @(negedge clk);
        n_run++;
        if ({wr_valid, wr_pc} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL order_c2: got wr=%0b pc=%h, expected wr=1 pc=00000100", wr_valid, wr_pc);
        end
        next_cycle();
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_run++;
        if ({wr_valid, wr_btype, wr_pc, wr_target} !== {1'b1, 2'b01, 32'h104, 32'h200}) begin
            n_fail++;
            $display("FAIL order_c3: got wr=%0b bt=%0d pc=%h tgt=%h, expected wr=1 bt=1 pc=00000104 tgt=00000200",
                     wr_valid, wr_btype, wr_pc, wr_target);
        end
        next_cycle();
        @(negedge clk);
        n_run++;
        if ({wr_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL order_c4: got wr=%0b busy=%0b, expected 0 0", wr_valid, busy);
        end
        next_cycle();
    endtask

    task automatic test_full_stall();
        MEM_DONE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_ex(1'b1, 2'b10, 1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i), $urandom);
            @(negedge clk);
            n_run++;
            if ({ex_ready, wr_valid} !== {(i < FIFO_DEPTH), 1'b0}) begin
                n_fail++;
                $display("FAIL full_accept%0d: got rdy=%0b wr=%0b, expected rdy=%0b wr=0",
                         i, ex_ready, wr_valid, (i < FIFO_DEPTH));
            end
            if (i < 4) next_cycle();
        end
        next_cycle();
        MEM_DONE = 1'b1;
        @(negedge clk);
        n_run++;
        if ({ex_ready, wr_valid, wr_pc} !== {2'b11, 32'h1000}) begin
            n_fail++;
            $display("FAIL full_release: got rdy=%0b wr=%0b pc=%h, expected rdy=1 wr=1 pc=00001000",
                     ex_ready, wr_valid, wr_pc);
        end
        next_cycle();
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drain("full");
    endtask

    task automatic test_filter();
        logic [1:0] bts [2];
        bts[0] = 2'b00;
        bts[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, bts[i], 1'b1, 32'h2000 + 32'(i), 32'h3000);
            @(negedge clk);
            n_run++;
            if (ex_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL filter_ready%0d: got rdy=%0b, expected 1", i, ex_ready);
            end
            next_cycle();
        end
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if ({wr_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL filter_idle%0d: got wr=%0b busy=%0b, expected 0 0", i, wr_valid, busy);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        MEM_DONE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, 2'b10, 1'b0, 32'h4000 + 32'(4 * i), 32'h5000);
            next_cycle();
        end
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        MEM_DONE  = 1'b1;
        irq_flush = 1'b1;
        @(negedge clk);
        n_run++;
        if ({wr_valid, ex_ready, pred_en, busy} !== 4'b0011) begin
            n_fail++;
            $display("FAIL flush_irq_cycle: got wr=%0b rdy=%0b pred=%0b busy=%0b, expected 0 0 1 1",
                     wr_valid, ex_ready, pred_en, busy);
        end
        next_cycle();
        irq_flush = 1'b0;
        walk_once(-1);
        check_run("flush");
        drain("flush");
    endtask

    task automatic test_restart();
        irq_flush = 1'b1;
        next_cycle();
        irq_flush = 1'b0;
        walk_once(7);
        walk_once(-1);
        check_run("restart");
    endtask

    task automatic test_collision();
        drive_ex(1'b1, 2'b10, 1'b1, 32'h300, 32'h340);
        irq_flush = 1'b1;
        @(negedge clk);
        n_run++;
        if (ex_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: got rdy=%0b, expected 0", ex_ready);
        end
        next_cycle();
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        irq_flush = 1'b0;
        walk_once(-1);
        check_run("collide");
        drain("collide");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 120; c++) begin
            drive_ex(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom);
            IF_DONE  = ($urandom_range(0, 3) != 0);
            MEM_DONE = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        IF_DONE  = 1'b1;
        MEM_DONE = 1'b1;
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        MEM_DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 2'b01, 1'b1, 32'h6000 + 32'(4 * i), 32'h7000);
            next_cycle();
        end
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        MEM_DONE = 1'b1;
        #1;
        n_run++;
        if ({wr_valid, busy, wr_pc} !== {2'b11, 32'h6000}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got wr=%0b busy=%0b pc=%h, expected 1 1 00006000", wr_valid, busy, wr_pc);
        end
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_run++;
        if ({wr_valid, clr_valid, wr_btype, wr_taken, wr_pc, wr_target, clr_idx, pred_en, ex_ready, busy}
            !== {73'd0, 4'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL rstmid_async: got wr=%0b clr=%0b pc=%h idx=%0d pred=%0b rdy=%0b busy=%0b, expected 0 0 0 0 1 1 0",
                     wr_valid, clr_valid, wr_pc, clr_idx, pred_en, ex_ready, busy);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        n_run++;
        if ({busy, ex_ready, wr_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL rstmid_after: got busy=%0b rdy=%0b wr=%0b, expected 0 1 0", busy, ex_ready, wr_valid);
        end
        check_run("rstmid");
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        IF_DONE   = 1'b1;
        MEM_DONE  = 1'b1;
        irq_flush = 1'b0;
        drive_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_order();
        test_full_stall();
        test_filter();
        test_flush();
        test_restart();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
